// File: rtl/univ_shift_reg.sv
// Universal WIDTH-bit shift register: per-cycle shift/rotate/load plus a burst
// engine that performs N back-to-back shifts under a start/busy/done handshake.
module univ_shift_reg #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic [2:0]       mode_i,
    input  logic             sl_i,
    input  logic             sr_i,
    input  logic [WIDTH-1:0] load_i,
    input  logic             burst_start_i,
    input  logic [CNT_W-1:0] burst_len_i,
    output logic [WIDTH-1:0] sr_o,
    output logic             msb_o,
    output logic             lsb_o,
    output logic             busy_o,
    output logic             done_o
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_SHL  = 3'b001;
    localparam logic [2:0] MODE_SHR  = 3'b010;
    localparam logic [2:0] MODE_ASR  = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_ROR  = 3'b101;
    localparam logic [2:0] MODE_LOAD = 3'b110;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    // Next register value for one application of a mode; 111 falls to HOLD.
    function automatic logic [WIDTH-1:0] apply_mode(
        input logic [2:0]       mode,
        input logic [WIDTH-1:0] cur,
        input logic             sl,
        input logic             sr,
        input logic [WIDTH-1:0] ld
    );
        case (mode)
            MODE_HOLD: apply_mode = cur;
            MODE_SHL:  apply_mode = {cur[WIDTH-2:0], sl};
            MODE_SHR:  apply_mode = {sr, cur[WIDTH-1:1]};
            MODE_ASR:  apply_mode = {cur[WIDTH-1], cur[WIDTH-1:1]};
            MODE_ROL:  apply_mode = {cur[WIDTH-2:0], cur[WIDTH-1]};
            MODE_ROR:  apply_mode = {cur[0], cur[WIDTH-1:1]};
            MODE_LOAD: apply_mode = ld;
            default:   apply_mode = cur;
        endcase
    endfunction

    function automatic logic is_shift(input logic [2:0] mode);
        is_shift = (mode >= MODE_SHL) && (mode <= MODE_ROR);
    endfunction

    state_t           state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [2:0]       bmode_r, bmode_s;
    logic [WIDTH-1:0] sr_r, sr_s;
    logic             busy_r;
    logic             done_r, done_s;

    // Next-state, counter, burst-mode and register-data selection.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        bmode_s = bmode_r;
        sr_s    = sr_r;
        done_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (burst_start_i) begin
                    if (is_shift(mode_i) && (burst_len_i != CNT_ZERO)) begin
                        state_s = ST_SHIFT;
                        cnt_s   = burst_len_i;
                        bmode_s = mode_i;
                    end else begin
                        // Degenerate request: acknowledge without touching the register.
                        done_s = 1'b1;
                    end
                end else if (en_i) begin
                    sr_s = apply_mode(mode_i, sr_r, sl_i, sr_i, load_i);
                end else begin
                    sr_s = sr_r;
                end
            end
            ST_SHIFT: begin
                sr_s  = apply_mode(bmode_r, sr_r, sl_i, sr_i, load_i);
                cnt_s = cnt_r - CNT_ONE;
                if (cnt_r == CNT_ONE) begin
                    state_s = ST_IDLE;
                    done_s  = 1'b1;
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = CNT_ZERO;
                bmode_s = MODE_HOLD;
            end
        endcase
    end

    // State, datapath and registered handshake outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
            bmode_r <= MODE_HOLD;
            sr_r    <= {WIDTH{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            bmode_r <= bmode_s;
            sr_r    <= sr_s;
            busy_r  <= (state_s == ST_SHIFT);
            done_r  <= done_s;
        end
    end

    assign sr_o   = sr_r;
    assign msb_o  = sr_r[WIDTH-1];
    assign lsb_o  = sr_r[0];
    assign busy_o = busy_r;
    assign done_o = done_r;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg: directed test-plan steps followed by
// randomized traffic, all compared against an arithmetic reference model.
module tb_univ_shift_reg;

    localparam int W     = 8;
    localparam int CNT_W = $clog2(W + 1);
    localparam int MODV  = 2 ** W;

    logic             clk;
    logic             reset;
    logic             en;
    logic [2:0]       mode;
    logic             sl;
    logic             srin;
    logic [W-1:0]     load;
    logic             bstart;
    logic [CNT_W-1:0] blen;
    logic [W-1:0]     sr_o;
    logic             msb_o, lsb_o, busy_o, done_o;

    univ_shift_reg #(.WIDTH(W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .en_i(en), .mode_i(mode), .sl_i(sl),
        .sr_i(srin), .load_i(load), .burst_start_i(bstart),
        .burst_len_i(blen), .sr_o(sr_o), .msb_o(msb_o), .lsb_o(lsb_o),
        .busy_o(busy_o), .done_o(done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: register value, shifts still owed by a burst, burst mode.
    int unsigned m_sr;
    int          m_rem;
    int unsigned m_bmode;
    bit          m_done;

    function automatic int unsigned ref_op(int unsigned md, int unsigned v,
                                           int unsigned s_l, int unsigned s_r,
                                           int unsigned ld);
        case (md)
            1: return (v * 2 + s_l) % MODV;
            2: return v / 2 + s_r * (MODV / 2);
            3: return v / 2 + (v >= MODV / 2 ? MODV / 2 : 0);
            4: return (v * 2) % MODV + v / (MODV / 2);
            5: return v / 2 + (v % 2) * (MODV / 2);
            6: return ld;
            default: return v;
        endcase
    endfunction

    task automatic model_reset();
        m_sr = 0; m_rem = 0; m_bmode = 0; m_done = 0;
    endtask

    task automatic model_edge();
        bit d;
        d = 0;
        if (m_rem > 0) begin
            m_sr = ref_op(m_bmode, m_sr, sl, srin, load);
            m_rem--;
            if (m_rem == 0) d = 1;
        end else if (bstart) begin
            if (mode >= 1 && mode <= 5 && blen != 0) begin
                m_rem = blen; m_bmode = mode;
            end else begin
                d = 1;
            end
        end else if (en) begin
            m_sr = ref_op(mode, m_sr, sl, srin, load);
        end
        m_done = d;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".sr"},   sr_o,   m_sr);
        chk({tag, ".msb"},  msb_o,  (m_sr / (MODV / 2)) % 2);
        chk({tag, ".lsb"},  lsb_o,  m_sr % 2);
        chk({tag, ".busy"}, busy_o, (m_rem > 0) ? 1 : 0);
        chk({tag, ".done"}, done_o, m_done);
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        chk_all(tag);
    endtask

    task automatic cyc(input string tag, input logic e, input logic [2:0] md,
                       input logic s_l, input logic s_r, input logic [W-1:0] ld,
                       input logic bs, input logic [CNT_W-1:0] bl);
        en = e; mode = md; sl = s_l; srin = s_r; load = ld; bstart = bs; blen = bl;
        tick(tag);
    endtask

    int busy_cnt, done_cnt;

    initial begin
        reset = 1'b1; en = 1'b0; mode = 3'd0; sl = 1'b0; srin = 1'b0;
        load = '0; bstart = 1'b0; blen = '0;
        model_reset();
        #2;
        chk_all("reset");
        @(posedge clk);
        #3 reset = 1'b0;

        // Single steps from 0xA5.
        cyc("load", 1'b1, 3'b110, 1'b0, 1'b0, 8'hA5, 1'b0, 4'd0);
        chk("load_a5", sr_o, 32'hA5);
        cyc("shl", 1'b1, 3'b001, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0);
        chk("shl_4a", sr_o, 32'h4A);
        cyc("reload", 1'b1, 3'b110, 1'b0, 1'b0, 8'hA5, 1'b0, 4'd0);
        cyc("shr", 1'b1, 3'b010, 1'b0, 1'b1, 8'h00, 1'b0, 4'd0);
        chk("shr_d2", sr_o, 32'hD2);
        cyc("reload", 1'b1, 3'b110, 1'b0, 1'b0, 8'hA5, 1'b0, 4'd0);
        cyc("asr", 1'b1, 3'b011, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0);
        chk("asr_d2", sr_o, 32'hD2);
        cyc("reload", 1'b1, 3'b110, 1'b0, 1'b0, 8'hA5, 1'b0, 4'd0);
        cyc("rol", 1'b1, 3'b100, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0);
        chk("rol_4b", sr_o, 32'h4B);
        cyc("reload", 1'b1, 3'b110, 1'b0, 1'b0, 8'hA5, 1'b0, 4'd0);
        cyc("ror", 1'b1, 3'b101, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0);
        chk("ror_d2", sr_o, 32'hD2);
        cyc("rsvd", 1'b1, 3'b111, 1'b1, 1'b1, 8'hFF, 1'b0, 4'd0);
        chk("rsvd_hold", sr_o, 32'hD2);

        // Burst ROL x8 on 0x81 with en/mode noise during the burst.
        cyc("load81", 1'b1, 3'b110, 1'b0, 1'b0, 8'h81, 1'b0, 4'd0);
        cyc("rol8_start", 1'b0, 3'b100, 1'b0, 1'b0, 8'h00, 1'b1, 4'd8);
        busy_cnt = (busy_o === 1'b1) ? 1 : 0;
        done_cnt = 0;
        for (int i = 0; i < 9; i++) begin
            cyc("rol8", i[0], 3'b110, 1'b1, 1'b1, 8'h3C, i[1], 4'd2);
            if (busy_o === 1'b1) busy_cnt++;
            if (done_o === 1'b1) done_cnt++;
        end
        chk("rol8_busy_cycles", busy_cnt, 32'd8);
        chk("rol8_done_pulses", done_cnt, 32'd1);
        chk("rol8_final", sr_o, 32'h81);

        // Burst SHL x3 from 0 with sl = 1,0,1, then back-to-back burst.
        cyc("load00", 1'b1, 3'b110, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0);
        cyc("shl3_start", 1'b0, 3'b001, 1'b0, 1'b0, 8'h00, 1'b1, 4'd3);
        cyc("shl3_e1", 1'b0, 3'b000, 1'b1, 1'b0, 8'h00, 1'b0, 4'd0);
        cyc("shl3_e2", 1'b0, 3'b000, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0);
        cyc("shl3_e3", 1'b0, 3'b000, 1'b1, 1'b0, 8'h00, 1'b0, 4'd0);
        chk("shl3_result", sr_o, 32'h05);
        chk("shl3_done", done_o, 32'd1);
        cyc("b2b_start", 1'b0, 3'b101, 1'b0, 1'b0, 8'h00, 1'b1, 4'd2);
        chk("b2b_busy", busy_o, 32'd1);
        cyc("b2b_e1", 1'b0, 3'b000, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0);
        cyc("b2b_e2", 1'b0, 3'b000, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0);
        chk("b2b_result", sr_o, 32'h41);

        // Degenerate bursts.
        cyc("deg_len0", 1'b1, 3'b001, 1'b1, 1'b0, 8'h00, 1'b1, 4'd0);
        chk("deg_len0_done", done_o, 32'd1);
        chk("deg_len0_sr", sr_o, 32'h41);
        cyc("deg_load", 1'b1, 3'b110, 1'b0, 1'b0, 8'hEE, 1'b1, 4'd5);
        chk("deg_load_done", done_o, 32'd1);
        chk("deg_load_busy", busy_o, 32'd0);
        chk("deg_load_sr", sr_o, 32'h41);
        cyc("deg_after", 1'b0, 3'b000, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0);

        // Reset during the 2nd cycle of an ASR x6 burst.
        cyc("loadf0", 1'b1, 3'b110, 1'b0, 1'b0, 8'hF0, 1'b0, 4'd0);
        cyc("asr6_start", 1'b0, 3'b011, 1'b0, 1'b0, 8'h00, 1'b1, 4'd6);
        cyc("asr6_e1", 1'b0, 3'b000, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0);
        #2 reset = 1'b1;
        #1;
        model_reset();
        chk_all("midreset");
        #2 reset = 1'b0;
        for (int i = 0; i < 7; i++)
            cyc("post_reset_idle", 1'b0, 3'b000, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0);
        cyc("loadb4", 1'b1, 3'b110, 1'b0, 1'b0, 8'hB4, 1'b0, 4'd0);
        cyc("asr3_start", 1'b0, 3'b011, 1'b0, 1'b0, 8'h00, 1'b1, 4'd3);
        for (int i = 0; i < 3; i++)
            cyc("asr3", 1'b0, 3'b000, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0);
        chk("asr3_result", sr_o, 32'hF6);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            cyc("rand", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                W'($urandom), 1'($urandom_range(0, 7) == 0),
                CNT_W'($urandom_range(0, 2 ** CNT_W - 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
